// File: rtl/led_cmd_parser_pkg.sv
// Shared encodings and ASCII constants for the LED command parser.
// Parser and transmit FSM states, channel selector, protocol bytes.
package led_cmd_parser_pkg;

  typedef enum logic [1:0] {P_IDLE, P_HI, P_LO, P_TERM} p_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT_HI, T_WAIT_LO} t_state_e;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_e;

  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_G_UP = 8'h47;
  localparam logic [7:0] ASCII_G_LO = 8'h67;
  localparam logic [7:0] ASCII_B_UP = 8'h42;
  localparam logic [7:0] ASCII_B_LO = 8'h62;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_K    = 8'h4B;
  localparam logic [7:0] ASCII_Q    = 8'h3F;

  // Cycles spent in T_WAIT_HI before a missing busy handshake is abandoned.
  localparam int TX_TIMEOUT = 4;

endpackage

// File: rtl/tx_req_hold.sv
// Single-entry response holder driving a UART transmitter start/busy handshake.
// Responses arriving while a transfer is pending or in flight are discarded.
module tx_req_hold
  import led_cmd_parser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  input  logic [7:0] req_data_i,
  input  logic       tx_busy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  output logic       drop_o
);

  t_state_e   state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       drop_q, drop_d;
  logic [1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T_IDLE;
      data_q  <= 8'h00;
      drop_q  <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    // A busy line in T_IDLE (e.g. after timeout recovery) also blocks a new start.
    if (req_valid_i && (state_q != T_IDLE || tx_busy_i)) drop_d = 1'b1;
    case (state_q)
      T_IDLE: begin
        if (req_valid_i && !tx_busy_i) begin
          data_d  = req_data_i;
          state_d = T_START;
        end
      end
      T_START: begin
        cnt_d   = 2'd0;
        state_d = tx_busy_i ? T_WAIT_LO : T_WAIT_HI;
      end
      T_WAIT_HI: begin
        if (tx_busy_i)                        state_d = T_WAIT_LO;
        else if (cnt_q == 2'(TX_TIMEOUT - 1)) state_d = T_IDLE;
        else                                  cnt_d   = cnt_q + 2'd1;
      end
      T_WAIT_LO: begin
        if (!tx_busy_i) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign tx_data_o  = data_q;
  assign tx_start_o = (state_q == T_START);
  assign drop_o     = drop_q;

endmodule

// File: rtl/led_cmd_parser.sv
// ASCII command parser: "<R|G|B><hex><hex><CR|LF>" sets an 8-bit PWM duty value
// and answers 'K' on success or '?' on any malformed byte.
module led_cmd_parser
  import led_cmd_parser_pkg::*;
#(
  parameter logic [7:0] RESET_DUTY = 8'h00,
  parameter logic       ACK_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_busy_i,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       drop_o
);

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_nib(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
  endfunction

  p_state_e   p_q, p_d;
  chan_e      chan_q, chan_d;
  logic [3:0] hi_q, hi_d, lo_q, lo_d;
  logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic       resp_valid, err, is_term;
  logic [7:0] resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= P_IDLE;
      chan_q  <= CH_R;
      hi_q    <= 4'h0;
      lo_q    <= 4'h0;
      red_q   <= RESET_DUTY;
      green_q <= RESET_DUTY;
      blue_q  <= RESET_DUTY;
    end else begin
      p_q     <= p_d;
      chan_q  <= chan_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign is_term = (rx_data_i == ASCII_CR) || (rx_data_i == ASCII_LF);

  always_comb begin
    p_d        = p_q;
    chan_d     = chan_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    resp_valid = 1'b0;
    resp_data  = ASCII_K;
    err        = 1'b0;
    if (rx_valid_i) begin
      case (p_q)
        P_IDLE: begin
          if (rx_data_i == ASCII_R_UP || rx_data_i == ASCII_R_LO) begin
            chan_d = CH_R; p_d = P_HI;
          end else if (rx_data_i == ASCII_G_UP || rx_data_i == ASCII_G_LO) begin
            chan_d = CH_G; p_d = P_HI;
          end else if (rx_data_i == ASCII_B_UP || rx_data_i == ASCII_B_LO) begin
            chan_d = CH_B; p_d = P_HI;
          end else if (!is_term) begin
            err = 1'b1;
          end
        end
        P_HI: begin
          if (is_hex(rx_data_i)) begin hi_d = hex_nib(rx_data_i); p_d = P_LO; end
          else err = 1'b1;
        end
        P_LO: begin
          if (is_hex(rx_data_i)) begin lo_d = hex_nib(rx_data_i); p_d = P_TERM; end
          else err = 1'b1;
        end
        P_TERM: begin
          if (is_term) begin
            case (chan_q)
              CH_R:    red_d   = {hi_q, lo_q};
              CH_G:    green_d = {hi_q, lo_q};
              CH_B:    blue_d  = {hi_q, lo_q};
              default: ;
            endcase
            p_d        = P_IDLE;
            resp_valid = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: p_d = P_IDLE;
      endcase
    end
    if (err) begin
      p_d        = P_IDLE;
      resp_valid = 1'b1;
      resp_data  = ASCII_Q;
    end
  end

  tx_req_hold u_tx (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (resp_valid & ACK_EN),
    .req_data_i  (resp_data),
    .tx_busy_i   (tx_busy_i),
    .tx_data_o   (tx_data_o),
    .tx_start_o  (tx_start_o),
    .drop_o      (drop_o)
  );

  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

endmodule

// File: tb/tb_led_cmd_parser.sv
// Scoreboard bench for led_cmd_parser: stimulus pushes expected response bytes,
// a monitor pops and compares them on every tx_start_o pulse.
module tb_led_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [7:0] red, green, blue;
  logic       drop;
  logic       nobusy = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  led_cmd_parser #(.RESET_DUTY(8'h00), .ACK_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .tx_busy_i  (tx_busy),
    .red_o      (red),
    .green_o    (green),
    .blue_o     (blue),
    .drop_o     (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transmitter model: busy rises the cycle after a start and lasts 6 cycles.
  initial forever begin
    @(negedge clk);
    if (!rst && tx_start && !nobusy) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat (6) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // Monitor: every start must match the oldest expected response.
  initial forever begin
    @(negedge clk);
    if (!rst && tx_start) begin
      check("start_while_busy", {7'd0, tx_busy}, 8'h00);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_start: got byte %h, expected no transfer", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("tx byte %h expected %h at %0t", tx_data, e, $time);
        check("tx_data", tx_data, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_cmd(input logic [7:0] c, h, l, t, input logic [7:0] resp);
    exp_q.push_back(resp);
    send(c); send(h); send(l); send(t);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic wait_busy();
    int k;
    k = 0;
    while (!tx_busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("busy_seen", {7'd0, tx_busy}, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_red", red, 8'h00);
    check("rst_green", green, 8'h00);
    check("rst_blue", blue, 8'h00);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_start", {7'd0, tx_start}, 8'h00);
    check("rst_drop", {7'd0, drop}, 8'h00);
    rst = 1'b0;
    idle(2);

    // "R80\r": exact commit and start timing around the CR pulse
    exp_q.push_back(8'h4B);
    send("R"); send("8"); send("0");
    @(posedge clk); #1;
    rx_data = 8'h0D; rx_valid = 1'b1;
    check("red_before_commit", red, 8'h00);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("red_after_cr", red, 8'h80);
    check("start_latency", {7'd0, tx_start}, 8'h01);
    idle(14);

    // "gFf\n": lowercase letter, mixed-case hex, LF terminator
    send_cmd("g", "F", "f", 8'h0A, 8'h4B);
    idle(1);
    check("green_ff", green, 8'hFF);
    check("red_kept", red, 8'h80);
    check("blue_kept", blue, 8'h00);
    idle(14);

    // "B1X" errors in P_LO; then a clean blue command
    exp_q.push_back(8'h3F);
    send("B"); send("1"); send("X");
    idle(1);
    check("blue_after_err", blue, 8'h00);
    idle(14);
    send_cmd("B", "2", "0", 8'h0D, 8'h4B);
    idle(1);
    check("blue_20", blue, 8'h20);
    idle(14);

    // Lost handshake: busy never rises, FSM must recover for the next command
    nobusy = 1'b1;
    send_cmd("b", "3", "3", 8'h0D, 8'h4B);
    idle(10);
    nobusy = 1'b0;
    check("blue_33", blue, 8'h33);
    send_cmd("G", "0", "1", 8'h0A, 8'h4B);
    idle(1);
    check("green_01", green, 8'h01);
    check("no_drop_after_timeout", {7'd0, drop}, 8'h00);
    idle(14);

    // Error while transmitter busy: response dropped, drop sticks
    send_cmd("R", "8", "0", 8'h0D, 8'h4B);
    wait_busy();
    send("X");
    idle(1);
    check("drop_set", {7'd0, drop}, 8'h01);
    idle(14);
    send(8'h0D);
    idle(4);
    check("drop_held", {7'd0, drop}, 8'h01);

    // Reset mid-command: partial "R4" discarded, "0" then errors from idle
    send("R"); send("4");
    do_reset();
    check("drop_cleared", {7'd0, drop}, 8'h00);
    check("red_reset", red, 8'h00);
    exp_q.push_back(8'h3F);
    send("0"); send(8'h0D);
    idle(14);
    check("red_after_partial", red, 8'h00);

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
